// File: rtl/branch_resolver_pkg.sv
// Shared core constants and types for branch resolution and flag consumers.
package branch_resolver_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned COND_W  = 4;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned CNT_W   = 3;

  // Branch opcodes
  localparam logic [OP_W-1:0] OP_B_IMM  = 5'd12;
  localparam logic [OP_W-1:0] OP_B_REG  = 5'd13;
  localparam logic [OP_W-1:0] OP_BL_REG = 5'd14;

  // Condition codes
  localparam logic [COND_W-1:0] CC_AL = 4'd0;
  localparam logic [COND_W-1:0] CC_EQ = 4'd1;
  localparam logic [COND_W-1:0] CC_NE = 4'd2;
  localparam logic [COND_W-1:0] CC_CS = 4'd3;
  localparam logic [COND_W-1:0] CC_CC = 4'd4;
  localparam logic [COND_W-1:0] CC_MI = 4'd5;
  localparam logic [COND_W-1:0] CC_PL = 4'd6;
  localparam logic [COND_W-1:0] CC_VS = 4'd7;
  localparam logic [COND_W-1:0] CC_VC = 4'd8;
  localparam logic [COND_W-1:0] CC_HI = 4'd9;
  localparam logic [COND_W-1:0] CC_LS = 4'd10;
  localparam logic [COND_W-1:0] CC_GE = 4'd11;
  localparam logic [COND_W-1:0] CC_LT = 4'd12;
  localparam logic [COND_W-1:0] CC_GT = 4'd13;
  localparam logic [COND_W-1:0] CC_LE = 4'd14;
  localparam logic [COND_W-1:0] CC_NV = 4'd15;

  // Flag bit positions within {O,S,Z,C}
  localparam int unsigned FLAG_O = 3;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  // Captured branch instruction
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [COND_W-1:0] cond;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   s_1;
    logic [XLEN-1:0]   imm;
  } br_req_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator against {O,S,Z,C} flags.
module cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [COND_W-1:0]  cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               taken
);

  logic f_o, f_s, f_z, f_c;

  assign f_o = flags[FLAG_O];
  assign f_s = flags[FLAG_S];
  assign f_z = flags[FLAG_Z];
  assign f_c = flags[FLAG_C];

  // Decode condition into a taken decision
  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_AL: taken = 1'b1;
      CC_EQ: taken = f_z;
      CC_NE: taken = !f_z;
      CC_CS: taken = f_c;
      CC_CC: taken = !f_c;
      CC_MI: taken = f_s;
      CC_PL: taken = !f_s;
      CC_VS: taken = f_o;
      CC_VC: taken = !f_o;
      CC_HI: taken = f_c && !f_z;
      CC_LS: taken = !f_c || f_z;
      CC_GE: taken = (f_s == f_o);
      CC_LT: taken = (f_s != f_o);
      CC_GT: taken = !f_z && (f_s == f_o);
      CC_LE: taken = f_z || (f_s != f_o);
      CC_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: captures a branch, waits for flags, redirects/faults, then squashes.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned FLUSH_SLOTS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     op,
  input  logic [COND_W-1:0]   cond,
  input  logic [XLEN-1:0]     pc,
  input  logic [XLEN-1:0]     s_1,
  input  logic [XLEN-1:0]     imm,
  input  logic [FLAGS_W-1:0]  flags,
  input  logic                flags_busy,
  input  logic                kill,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  output logic                link_valid,
  output logic [XLEN-1:0]     link_data,
  output logic                fault_valid,
  output logic                squash
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  br_req_t           br_q, br_d;
  logic              in_ready_q, in_ready_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              link_valid_q, link_valid_d;
  logic [XLEN-1:0]   link_data_q, link_data_d;
  logic              fault_valid_q, fault_valid_d;
  logic              squash_q, squash_d;

  logic              cond_taken;
  logic              op_is_branch;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   pc_plus4;

  cond_eval u_cond_eval (
    .cond  (br_q.cond),
    .flags (flags),
    .taken (cond_taken)
  );

  // Target and link address from the captured branch
  always_comb begin
    pc_plus4     = br_q.pc + XLEN'(4);
    op_is_branch = (br_q.op == OP_B_IMM) || (br_q.op == OP_B_REG) || (br_q.op == OP_BL_REG);
    target       = (br_q.op == OP_B_IMM) ? (pc_plus4 + br_q.imm) : br_q.s_1;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    br_d             = br_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    link_valid_d     = 1'b0;
    link_data_d      = '0;
    fault_valid_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q && !kill) begin
          br_d    = '{op: op, cond: cond, pc: pc, s_1: s_1, imm: imm};
          state_d = flags_busy ? ST_WAIT : ST_RESOLVE;
        end
      end
      ST_WAIT: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else if (!flags_busy) begin
          state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else if (op_is_branch && cond_taken) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_SLOTS);
          if (target[1:0] != 2'b00) begin
            fault_valid_d = 1'b1;
          end else begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target;
            if (br_q.op == OP_BL_REG) begin
              link_valid_d = 1'b1;
              link_data_d  = pc_plus4;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (kill || (cnt_q <= CNT_W'(1))) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
    squash_d   = (state_d == ST_FLUSH);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      br_q             <= '0;
      in_ready_q       <= 1'b1;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      link_valid_q     <= 1'b0;
      link_data_q      <= '0;
      fault_valid_q    <= 1'b0;
      squash_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      br_q             <= br_d;
      in_ready_q       <= in_ready_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      link_valid_q     <= link_valid_d;
      link_data_q      <= link_data_d;
      fault_valid_q    <= fault_valid_d;
      squash_q         <= squash_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign link_valid     = link_valid_q;
  assign link_data      = link_data_q;
  assign fault_valid    = fault_valid_q;
  assign squash         = squash_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with hand-computed expectations.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [3:0]  cond;
  logic [31:0] pc;
  logic [31:0] s_1;
  logic [31:0] imm;
  logic [3:0]  flags;
  logic        flags_busy;
  logic        kill;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        link_valid;
  logic [31:0] link_data;
  logic        fault_valid;
  logic        squash;

  int checks = 0;
  int errors = 0;

  branch_resolver #(.FLUSH_SLOTS(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .op             (op),
    .cond           (cond),
    .pc             (pc),
    .s_1            (s_1),
    .imm            (imm),
    .flags          (flags),
    .flags_busy     (flags_busy),
    .kill           (kill),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .link_valid     (link_valid),
    .link_data      (link_data),
    .fault_valid    (fault_valid),
    .squash         (squash)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Offer one branch and clock the accepting edge
  task automatic offer(input logic [4:0] o, input logic [3:0] c, input logic [31:0] p,
                       input logic [31:0] s, input logic [31:0] i, input logic [3:0] f,
                       input logic busy);
    op = o; cond = c; pc = p; s_1 = s; imm = i; flags = f; flags_busy = busy;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0] c;
    logic [3:0] f;
    logic       exp;
  } cc_vec_t;

  cc_vec_t cc_tab [6];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; cond = '0; pc = '0; s_1 = '0;
    imm = '0; flags = '0; flags_busy = 1'b0; kill = 1'b0;

    cc_tab[0] = '{c: 4'd9,  f: 4'b0001, exp: 1'b1}; // hi: C & !Z
    cc_tab[1] = '{c: 4'd9,  f: 4'b0011, exp: 1'b0};
    cc_tab[2] = '{c: 4'd12, f: 4'b0100, exp: 1'b1}; // lt: S != O
    cc_tab[3] = '{c: 4'd13, f: 4'b1100, exp: 1'b1}; // gt: !Z & S==O
    cc_tab[4] = '{c: 4'd14, f: 4'b0000, exp: 1'b0}; // le
    cc_tab[5] = '{c: 4'd15, f: 4'b1111, exp: 1'b0}; // never

    // Reset state
    tick(); tick();
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_squash", 32'(squash), 32'd0);
    check("rst_link_data", link_data, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Taken op 12, eq with Z=1
    offer(5'd12, 4'd1, 32'h100, 32'h0, 32'h20, 4'b0010, 1'b0);
    check("t1_busy_in_ready", 32'(in_ready), 32'd0);
    check("t1_no_early_pulse", 32'(redirect_valid), 32'd0);
    tick();
    check("t1_redirect_valid", 32'(redirect_valid), 32'd1);
    check("t1_redirect_pc", redirect_pc, 32'h124);
    check("t1_squash_1", 32'(squash), 32'd1);
    check("t1_no_link", 32'(link_valid), 32'd0);
    tick();
    check("t1_pulse_one_cycle", 32'(redirect_valid), 32'd0);
    check("t1_squash_2", 32'(squash), 32'd1);
    check("t1_in_ready_flush", 32'(in_ready), 32'd0);
    tick();
    check("t1_squash_end", 32'(squash), 32'd0);
    check("t1_in_ready_back", 32'(in_ready), 32'd1);

    // Not taken op 12, eq with Z=0
    offer(5'd12, 4'd1, 32'h100, 32'h0, 32'h20, 4'b0000, 1'b0);
    tick();
    check("t2_no_redirect", 32'(redirect_valid), 32'd0);
    check("t2_no_squash", 32'(squash), 32'd0);
    check("t2_in_ready", 32'(in_ready), 32'd1);

    // Branch-and-link register
    offer(5'd14, 4'd0, 32'h200, 32'h4000, 32'h0, 4'b0000, 1'b0);
    tick();
    check("t3_redirect_valid", 32'(redirect_valid), 32'd1);
    check("t3_redirect_pc", redirect_pc, 32'h4000);
    check("t3_link_valid", 32'(link_valid), 32'd1);
    check("t3_link_data", link_data, 32'h204);
    tick();
    check("t3_link_one_cycle", 32'(link_valid), 32'd0);
    tick();
    check("t3_in_ready", 32'(in_ready), 32'd1);

    // Misaligned register target
    offer(5'd13, 4'd0, 32'h0, 32'h4002, 32'h0, 4'b0000, 1'b0);
    tick();
    check("t4_fault_valid", 32'(fault_valid), 32'd1);
    check("t4_no_redirect", 32'(redirect_valid), 32'd0);
    check("t4_no_link", 32'(link_valid), 32'd0);
    check("t4_squash_1", 32'(squash), 32'd1);
    tick();
    check("t4_fault_one_cycle", 32'(fault_valid), 32'd0);
    check("t4_squash_2", 32'(squash), 32'd1);
    tick();
    check("t4_squash_end", 32'(squash), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);

    // Flags busy for 3 cycles, Z set on release
    offer(5'd12, 4'd1, 32'h100, 32'h0, 32'h20, 4'b0000, 1'b1);
    tick();
    tick();
    flags_busy = 1'b0; flags = 4'b0010;
    tick();
    check("t5_no_pulse_yet", 32'(redirect_valid), 32'd0);
    tick();
    check("t5_redirect_valid", 32'(redirect_valid), 32'd1);
    check("t5_redirect_pc", redirect_pc, 32'h124);
    tick(); tick();
    check("t5_in_ready", 32'(in_ready), 32'd1);

    // Kill while waiting on flags
    offer(5'd13, 4'd0, 32'h0, 32'h800, 32'h0, 4'b0000, 1'b1);
    kill = 1'b1;
    tick();
    kill = 1'b0; flags_busy = 1'b0;
    check("t6_kill_in_ready", 32'(in_ready), 32'd1);
    check("t6_kill_squash", 32'(squash), 32'd0);
    tick();
    check("t6_kill_no_redirect", 32'(redirect_valid), 32'd0);

    // Reset pulsed while resolving
    offer(5'd13, 4'd0, 32'h0, 32'h300, 32'h0, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    #2;
    check("t7_rst_redirect", 32'(redirect_valid), 32'd0);
    check("t7_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("t7_post_rst_in_ready", 32'(in_ready), 32'd1);
    check("t7_post_rst_no_redirect", 32'(redirect_valid), 32'd0);
    check("t7_post_rst_no_squash", 32'(squash), 32'd0);

    // Kill during flush clears squash
    offer(5'd13, 4'd0, 32'h0, 32'h500, 32'h0, 4'b0000, 1'b0);
    tick();
    check("t8_squash_on", 32'(squash), 32'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("t8_kill_squash_off", 32'(squash), 32'd0);
    check("t8_kill_in_ready", 32'(in_ready), 32'd1);

    // Kill in idle blocks the transfer
    op = 5'd13; cond = 4'd0; s_1 = 32'h600; in_valid = 1'b1; kill = 1'b1;
    tick();
    in_valid = 1'b0; kill = 1'b0;
    check("t9_blocked_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("t9_blocked_no_redirect", 32'(redirect_valid), 32'd0);

    // Unknown opcode accepted, never taken
    offer(5'd5, 4'd0, 32'h0, 32'h700, 32'h0, 4'b0000, 1'b0);
    check("t10_accepted", 32'(in_ready), 32'd0);
    tick();
    check("t10_no_redirect", 32'(redirect_valid), 32'd0);
    check("t10_in_ready", 32'(in_ready), 32'd1);

    // Condition code spot checks via op 13 to an aligned target
    for (int k = 0; k < 6; k++) begin
      offer(5'd13, cc_tab[k].c, 32'h0, 32'h1000, 32'h0, cc_tab[k].f, 1'b0);
      tick();
      check($sformatf("cc_%0d_taken", k), 32'(redirect_valid), 32'(cc_tab[k].exp));
      tick(); tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter FLUSH_SLOTS, default 2, legal range 1..7: number of cycles squash is held after a taken branch.
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  in  1  branch instruction offered.
REQ-005 SHALL have port: in_ready  out  1  resolver can accept; a transfer occurs on an edge with in_valid & in_ready.
REQ-006 SHALL have port: op  in  5  opcode: 12 = branch immediate, 13 = branch register, 14 = branch-and-link register.
REQ-007 SHALL have port: cond  in  4  condition code.
REQ-008 SHALL have port: pc  in  32  branch instruction address.
REQ-009 SHALL have port: s_1  in  32  register target for op 13/14.
REQ-010 SHALL have port: imm  in  32  sign-extended byte offset for op 12.
REQ-011 SHALL have port: flags  in  4  ALU flags {O,S,Z,C} (bit3..bit0).
REQ-012 SHALL have port: flags_busy  in  1  a flag-writing ALU op has not yet committed its flags.
REQ-013 SHALL have port: kill  in  1  external flush from an older instruction.
REQ-014 SHALL have port: redirect_valid  out  1  one-cycle fetch redirect.
REQ-015 SHALL have port: redirect_pc  out  32  redirect target.
REQ-016 SHALL have port: link_valid / link_data  out  1 / 32  one-cycle link writeback (pc+4).
REQ-017 SHALL have port: fault_valid  out  1  one-cycle misaligned-target fault.
REQ-018 SHALL have port: squash  out  1  younger pipeline slots are invalid.

Function
REQ-019 SHALL implement states IDLE, WAIT, RESOLVE, FLUSH; in_ready = 1 only in IDLE.
REQ-020 On a transfer, SHALL capture op, cond, pc, s_1 and imm, and go to WAIT if flags_busy = 1, else to RESOLVE.
REQ-021 In WAIT, SHALL go to RESOLVE on the first edge with flags_busy = 0.
REQ-022 In RESOLVE, SHALL evaluate cond against the live flags input: 0 always, 1 eq Z, 2 ne !Z, 3 cs C, 4 cc !C, 5 mi S, 6 pl !S, 7 vs O, 8 vc !O, 9 hi C&!Z, 10 ls !C|Z, 11 ge S==O, 12 lt S!=O, 13 gt !Z&(S==O), 14 le Z|(S!=O), 15 never.
REQ-023 SHALL compute target modulo 2^32: op 12 -> pc + 4 + imm; op 13/14 -> s_1.
REQ-024 On the edge leaving RESOLVE, when taken with target[1:0] = 0, SHALL assert redirect_valid with redirect_pc = target for exactly one cycle.
REQ-025 On the edge leaving RESOLVE, when taken with target[1:0] != 0, SHALL assert fault_valid for exactly one cycle with no redirect and no link.
REQ-026 On the edge leaving RESOLVE, op 14 taken without fault SHALL also assert link_valid with link_data = pc + 4.
REQ-027 SHALL not produce a link when op 14 is not taken.
REQ-028 On the edge leaving RESOLVE, taken (redirect or fault) SHALL enter FLUSH with a counter of FLUSH_SLOTS; not taken SHALL return to IDLE with no output pulse.
REQ-029 squash SHALL be 1 exactly during the FLUSH_SLOTS cycles in FLUSH; the counter decrements each edge, and the resolver returns to IDLE when it reaches 0.
REQ-030 Latency: transfer at edge N with flags_busy = 0 gives a pulse in the cycle after edge N+1; each WAIT cycle adds one cycle.
REQ-031 kill = 1 in WAIT or RESOLVE SHALL return to IDLE with no pulses.
REQ-032 kill = 1 in FLUSH SHALL return to IDLE and clear squash.
REQ-033 kill = 1 in IDLE SHALL block any transfer that edge.
REQ-034 An op outside {12,13,14} SHALL be accepted and treated as not taken.

Reset
REQ-035 While rst_n = 0 (asynchronously), SHALL hold the state at IDLE and the flush counter at 0.
REQ-036 While rst_n = 0, SHALL hold redirect_valid, link_valid, fault_valid and squash at 0, and redirect_pc and link_data at 0.
REQ-037 Reset mid-operation SHALL discard the captured branch; in_ready = 1 in the first cycle after rst_n rises.

Structure
REQ-038 SHALL place the opcode constants (12/13/14), condition-code constants (0..15) and flag bit indices (O=3, S=2, Z=1, C=0) in the shared core package.
REQ-039 SHALL implement condition evaluation as combinational sub-module cond_eval (cond, flags -> taken), reusable by other consumers of the flags.

Verification
REQ-040 Test: op 12, cond 1, pc 0x100, imm 0x20, flags 0b0010, flags_busy 0 -> redirect_pc 0x124 pulse 2 cycles after accept, then squash for 2 cycles, then in_ready 1.
REQ-041 Test: op 12, cond 1, flags 0b0000 -> no pulse, squash 0, in_ready 1 again 2 cycles after accept.
REQ-042 Test: op 14, cond 0, pc 0x200, s_1 0x4000 -> redirect_pc 0x4000 and link_data 0x204 in the same cycle.
REQ-043 Test: op 13, cond 0, s_1 0x4002 -> fault_valid pulse, no redirect, no link, squash for 2 cycles.
REQ-044 Test: flags_busy held 3 cycles after accept, with flags changing to Z=1 on release, cond 1 -> resolves as taken and pulses 3 cycles later than in REQ-040.
REQ-045 Test: kill asserted in WAIT, and separately rst_n pulsed low in RESOLVE -> no pulses, outputs 0, in_ready 1 next cycle.
